ab_sequence_driver: RTL
=======================

# ab_sequence_driver

Stimulus generator and response checker for the a→b sequence detector. On a `start` request it drives a programmable number of back-to-back "a then b" patterns on its `a`/`b` outputs. Each pattern is followed by a wait slot in which the detector's `q` must be high, and a fixed idle gap separates patterns. It counts missing and spurious `q` pulses and reports pass/fail at the end. It sits beside the detector in self-test and bring-up configurations, with `a`/`b` wired to the detector inputs and the detector `q` wired back to `q_in`.

## Interface
- `REPS_W`, default 8: width of the repetition count.
- `ERR_W`, default 8: width of the error counter.
- `GAP_CYCLES`, default 2: idle cycles between consecutive patterns. Must be ≥1.

Ports:
- `clock` in 1: clock; all state changes on its rising edge.
- `reset` in 1: reset, synchronous, active-high.
- `start` in 1: request to run a sequence. Sampled only in IDLE.
- `reps` in REPS_W: number of patterns to drive. Sampled with `start`.
- `q_in` in 1: detector output fed back.
- `a` out 1: pattern bit a; high only in DRIVE_A.
- `b` out 1: pattern bit b; high only in DRIVE_B.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse in DONE.
- `pass` out 1: registered result, `err_count==0`. Valid from DONE until the next accepted `start`.
- `err_count` out ERR_W: missed plus spurious `q` events; saturates at all-ones.

## Operation
- The state machine has six states: IDLE, DRIVE_A, DRIVE_B, WAIT_Q, GAP, DONE.
- **IDLE:**
  - `start=1` with `reps≠0` → DRIVE_A. This loads `remaining=reps`, clears `err_count`, clears `pass`, and clears the gap counter.
  - `start=1` with `reps=0` → DONE directly. `err_count` is cleared; `pass=1`.
- **DRIVE_A** → DRIVE_B unconditionally.
- **DRIVE_B** → WAIT_Q unconditionally.
- **WAIT_Q:** `q_in` is sampled here.
  - `q_in=0` is a miss: `err_count` is incremented.
  - `remaining` is decremented.
  - If the new `remaining` is 0 → DONE; otherwise → GAP.
- **GAP:** stays for exactly GAP_CYCLES cycles, then → DRIVE_A.
- **DONE:** `done=1` and `pass` is updated, then → IDLE.
- **Spurious `q`:** `q_in=1` in DRIVE_A, DRIVE_B or GAP increments `err_count`, once per cycle. In IDLE and DONE, `q_in` is ignored.
- **Outputs:** `a`, `b`, `busy` and `done` are decoded from the registered state only (Moore). There is no combinational path from any input to any output.
- **Error counting:** `err_count` saturates and never wraps. `pass` is computed from the final `err_count`, including any WAIT_Q miss in the last pattern.
- **`start` while busy:** ignored; `reps` changes while busy are also ignored.
- **Reset:** state=IDLE; `a=b=busy=done=pass=0`; `err_count=0`; `remaining=0`. Reset wins over every other condition, including mid-pattern. `a`/`b` are low in the cycle after the reset edge.

## Timing
- Call the edge that samples `start` in IDLE E0; cycle 1 is the cycle after E0.
- For `reps=N≥1`:
  - Pattern k (k=0..N-1) starts at cycle `1 + k*(3+GAP_CYCLES)`.
  - `a` is high in the pattern's first cycle, `b` in its second.
  - `q_in` is checked in its third cycle, which is the detector's S2 cycle.
- `done` is high in cycle `3N + GAP_CYCLES*(N-1) + 1`. The block is back in IDLE, and able to accept `start`, one cycle later.
- `reps=0`: `done` is high in cycle 1.
- `busy` is high from cycle 1 through the `done` cycle inclusive.
- `err_count` is updated at the edge ending the offending cycle and is visible the next cycle.

## Structure
- **Package `ab_seq_pkg`:**
  - `typedef enum logic [2:0] drv_state_t` with the six states.
  - `localparam int unsigned PATTERN_LEN = 3`.
- **Sub-module `sat_counter`:**
  - Parameter WIDTH.
  - Inputs: `clock`, `reset`, `clr`, `inc`.
  - Output: `count`.
  - Saturating increment; `clr` has priority over `inc`.
  - Used for `err_count`.
- **Top level:** state register, next-state logic, `remaining` down-counter, and gap counter of width `$clog2(GAP_CYCLES+1)`.

## Test plan
- **Single pattern.** `reps=1`, GAP=2, detector model correct → `a` in cycle 1, `b` in cycle 2, `done` in cycle 4, `pass=1`, `err_count=0`.
- **Three patterns.** `reps=3`, GAP=2, correct detector → `a` in cycles 1, 6, 11; `done` in cycle 14; `pass=1`.
- **Missing `q`.** `reps=2`, `q_in` tied 0 → `err_count=2`, `pass=0`. Then `reps=1` with `q_in=1` only in WAIT_Q → `err_count` cleared at start and ends 0, `pass=1`.
- **Spurious `q`.** `q_in` forced 1 for all of a `reps=1` run → `err_count=2` (DRIVE_A, DRIVE_B; WAIT_Q passes). Then ERR_W=2 with `reps=4` and `q_in` held high → `err_count` saturates at 3.
- **Zero `reps` / `start` while busy.**
  - `reps=0` → `done` in cycle 1, `pass=1`, `a`/`b` never high.
  - `start` pulsed during GAP with `reps=7` → ignored; the original count completes.
- **Reset mid-operation.** Assert `reset` in DRIVE_B of pattern 2 of 5 → next cycle `a=b=busy=0`, `err_count=0`. A fresh `start` with `reps=1` then completes normally.

Source files
------------

// File: rtl/ab_seq_pkg.sv
// Shared types for the a->b sequence driver: FSM state encoding and pattern length.
package ab_seq_pkg;

  localparam int unsigned PATTERN_LEN = 3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRIVE_A,
    S_DRIVE_B,
    S_WAIT_Q,
    S_GAP,
    S_DONE
  } drv_state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear takes priority over increment.
module sat_counter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clock) begin
    if (reset || clr) begin
      count <= '0;
    end else if (inc && (count != {WIDTH{1'b1}})) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/ab_sequence_driver.sv
// Drives N "a then b" patterns into the sequence detector and scores its q response.
module ab_sequence_driver
  import ab_seq_pkg::*;
#(
  parameter int unsigned REPS_W     = 8,
  parameter int unsigned ERR_W      = 8,
  parameter int unsigned GAP_CYCLES = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [REPS_W-1:0] reps,
  input  logic              q_in,
  output logic              a,
  output logic              b,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ERR_W-1:0]  err_count
);

  localparam int unsigned GAP_W = $clog2(GAP_CYCLES + 1);

  drv_state_t        state;
  drv_state_t        state_nxt;
  logic [REPS_W-1:0] remaining;
  logic [GAP_W-1:0]  gap_cnt;
  logic              last_gap_c;
  logic              err_clr_c;
  logic              err_inc_c;

  assign last_gap_c = (gap_cnt == GAP_W'(GAP_CYCLES - 1));

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:    if (start) state_nxt = (reps == '0) ? S_DONE : S_DRIVE_A;
      S_DRIVE_A: state_nxt = S_DRIVE_B;
      S_DRIVE_B: state_nxt = S_WAIT_Q;
      S_WAIT_Q:  state_nxt = (remaining == REPS_W'(1)) ? S_DONE : S_GAP;
      S_GAP:     if (last_gap_c) state_nxt = S_DRIVE_A;
      S_DONE:    state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // A miss is no q in WAIT_Q; a spurious q is any q while driving or gapping.
  always_comb begin
    err_clr_c = (state == S_IDLE) && start;
    err_inc_c = ((state == S_WAIT_Q) && !q_in) ||
                (((state == S_DRIVE_A) || (state == S_DRIVE_B) || (state == S_GAP)) && q_in);
  end

  sat_counter #(.WIDTH(ERR_W)) u_err_cnt (
    .clock (clock),
    .reset (reset),
    .clr   (err_clr_c),
    .inc   (err_inc_c),
    .count (err_count)
  );

  // Moore outputs are registered from the next state so they line up with state.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= S_IDLE;
      remaining <= '0;
      gap_cnt   <= '0;
      a         <= 1'b0;
      b         <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
    end else begin
      state <= state_nxt;
      a     <= (state_nxt == S_DRIVE_A);
      b     <= (state_nxt == S_DRIVE_B);
      busy  <= (state_nxt != S_IDLE);
      done  <= (state_nxt == S_DONE);
      unique case (state)
        S_IDLE: begin
          if (start) begin
            remaining <= reps;
            gap_cnt   <= '0;
            pass      <= (reps == '0);
          end
        end
        S_WAIT_Q: begin
          remaining <= remaining - REPS_W'(1);
          gap_cnt   <= '0;
          // Fold the final miss in now so pass is already valid during DONE.
          if (state_nxt == S_DONE) pass <= (err_count == '0) && q_in;
        end
        S_GAP:   gap_cnt <= gap_cnt + GAP_W'(1);
        S_DONE:  pass <= (err_count == '0);
        default: ;
      endcase
    end
  end

endmodule
